// File: rtl/hv_flt_pkg.sv
// hv_flt_pkg: shared types for the HV fault manager.
//   hv_flt_st_e   : fault manager state (IDLE, ACTIVE, HOLDOFF, LOCKOUT)
//   FLT_ST_W      : width of the state encoding
//   pwm_for_state : PWM permission for a given state and kill request
package hv_flt_pkg;

  localparam int FLT_ST_W = 2;

  typedef enum logic [FLT_ST_W-1:0] {
    IDLE    = 2'd0,
    ACTIVE  = 2'd1,
    HOLDOFF = 2'd2,
    LOCKOUT = 2'd3
  } hv_flt_st_e;

  // PWM may run when idle, or while active and no kill-class source is set.
  function automatic logic pwm_for_state(input hv_flt_st_e st, input logic kill);
    logic en;
    en = 1'b0;
    case (st)
      IDLE:    en = 1'b1;
      ACTIVE:  en = ~kill;
      default: en = 1'b0;
    endcase
    return en;
  endfunction

endpackage

// File: rtl/hv_flt_mgr_if.sv
// hv_flt_mgr_if: bundle of the fault manager's configuration/error inputs
// and status outputs.
//   master : drives err/err_en/err_pwm_kill/dgl_cyc/hold_cyc/retry_max/clr,
//            observes the status outputs
//   slave  : the fault manager view (inputs and outputs reversed)
// All signals are levels sampled on the block clock; clr is a one-cycle
// pulse. There is no valid/ready handshake: every signal is valid on every
// cycle.
interface hv_flt_mgr_if #(
  parameter int ERR_NUM = 8,
  parameter int DGL_W   = 4,
  parameter int HOLD_W  = 16,
  parameter int RETRY_W = 3
);
  logic [ERR_NUM-1:0] err;
  logic [ERR_NUM-1:0] err_en;
  logic [ERR_NUM-1:0] err_pwm_kill;
  logic [DGL_W-1:0]   dgl_cyc;
  logic [HOLD_W-1:0]  hold_cyc;
  logic [RETRY_W-1:0] retry_max;
  logic               clr;
  logic [ERR_NUM-1:0] err_flt;
  logic [ERR_NUM-1:0] err_sticky;
  logic               fault;
  logic               pwm_en_mask;
  logic               intb_n;
  logic [1:0]         flt_st;
  logic [RETRY_W-1:0] retry_cnt;

  modport master (
    output err, err_en, err_pwm_kill, dgl_cyc, hold_cyc, retry_max, clr,
    input  err_flt, err_sticky, fault, pwm_en_mask, intb_n, flt_st, retry_cnt
  );

  modport slave (
    input  err, err_en, err_pwm_kill, dgl_cyc, hold_cyc, retry_max, clr,
    output err_flt, err_sticky, fault, pwm_en_mask, intb_n, flt_st, retry_cnt
  );
endinterface

// File: rtl/hv_flt_dgl.sv
// hv_flt_dgl: deglitch counter and comparator for one error source.
//   i_clk, i_rst : clock, async active-high reset
//   i_err, i_en  : raw error level and its enable
//   i_dgl_cyc    : threshold in cycles
//   o_flt_nxt    : next filtered value (registered by the parent)
module hv_flt_dgl #(
  parameter int DGL_W = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_err,
  input  logic             i_en,
  input  logic [DGL_W-1:0] i_dgl_cyc,
  output logic             o_flt_nxt
);

  logic [DGL_W-1:0] cnt_q, cnt_d;
  logic             act;

  assign act = i_err & i_en;

  // Counter saturates so a long fault never wraps back below threshold.
  always_comb begin
    cnt_d = '0;
    if (act) cnt_d = (&cnt_q) ? cnt_q : cnt_q + 1'b1;
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  // Release is immediate: act low forces the filtered value low.
  assign o_flt_nxt = act & (cnt_q >= i_dgl_cyc);

endmodule

// File: rtl/hv_flt_mgr.sv
// hv_flt_mgr: HV die fault manager.
// Filters ERR_NUM raw error flags, latches them as sticky bits, and runs an
// auto-recovery FSM (IDLE/ACTIVE/HOLDOFF/LOCKOUT) with a holdoff timer and
// retry limit. Drives fault request, PWM gate and INTB.
// Optional feature macro: HV_FLT_DGL_EN (per-source deglitch counters).
// Without it o_err_flt is simply registered (i_err & i_err_en).
// Ports:
//   i_clk, i_rst       : clock, async active-high reset
//   i_err, i_err_en    : raw error levels and per-source enables
//   i_err_pwm_kill     : sources that gate PWM while filtered-active
//   i_dgl_cyc          : deglitch threshold (unused without HV_FLT_DGL_EN)
//   i_hold_cyc         : holdoff length, HOLDOFF lasts i_hold_cyc+1 cycles
//   i_retry_max        : auto-recoveries allowed before lockout
//   i_clr              : clear pulse (sticky bits, retry count, lockout)
//   o_err_flt          : filtered errors
//   o_err_sticky       : latched filtered errors
//   o_fault            : state != IDLE
//   o_pwm_en_mask      : 1 = PWM permitted
//   o_intb_n           : active-low interrupt
//   o_flt_st           : current state
//   o_retry_cnt        : recoveries used
module hv_flt_mgr
  import hv_flt_pkg::*;
#(
  parameter int ERR_NUM = 8,
  parameter int DGL_W   = 4,
  parameter int HOLD_W  = 16,
  parameter int RETRY_W = 3
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic [ERR_NUM-1:0] i_err,
  input  logic [ERR_NUM-1:0] i_err_en,
  input  logic [ERR_NUM-1:0] i_err_pwm_kill,
  input  logic [DGL_W-1:0]   i_dgl_cyc,
  input  logic [HOLD_W-1:0]  i_hold_cyc,
  input  logic [RETRY_W-1:0] i_retry_max,
  input  logic               i_clr,
  output logic [ERR_NUM-1:0] o_err_flt,
  output logic [ERR_NUM-1:0] o_err_sticky,
  output logic               o_fault,
  output logic               o_pwm_en_mask,
  output logic               o_intb_n,
  output logic [1:0]         o_flt_st,
  output logic [RETRY_W-1:0] o_retry_cnt
);

  logic [ERR_NUM-1:0] flt_q, flt_d;
  logic [ERR_NUM-1:0] sticky_q, sticky_d;
  hv_flt_st_e         st_q, st_d;
  logic [RETRY_W-1:0] retry_q, retry_d;
  logic [HOLD_W-1:0]  timer_q, timer_d;
  logic               pwm_q, pwm_d;
  logic               intb_q, intb_d;
  logic               any_flt, kill;

`ifdef HV_FLT_DGL_EN
  for (genvar k = 0; k < ERR_NUM; k++) begin : g_dgl
    hv_flt_dgl #(.DGL_W(DGL_W)) u_dgl (
      .i_clk     (i_clk),
      .i_rst     (i_rst),
      .i_err     (i_err[k]),
      .i_en      (i_err_en[k]),
      .i_dgl_cyc (i_dgl_cyc),
      .o_flt_nxt (flt_d[k])
    );
  end
`else
  logic unused_dgl;
  assign unused_dgl = ^i_dgl_cyc;
  assign flt_d      = i_err & i_err_en;
`endif

  // FSM and outputs act on the registered filtered flags, so the state
  // follows o_err_flt by exactly one edge.
  assign any_flt = |flt_q;
  assign kill    = |(flt_q & i_err_pwm_kill);

  // Set wins over a simultaneous clear.
  assign sticky_d = (i_clr ? '0 : sticky_q) | flt_q;

  always_comb begin
    st_d    = st_q;
    retry_d = retry_q;
    timer_d = timer_q;
    case (st_q)
      IDLE: begin
        if (i_clr)   retry_d = '0;
        if (any_flt) st_d    = ACTIVE;
      end
      ACTIVE: begin
        if (!any_flt) begin
          if (retry_q >= i_retry_max) begin
            st_d = LOCKOUT;
          end else begin
            st_d    = HOLDOFF;
            retry_d = retry_q + 1'b1;
            timer_d = '0;
          end
        end
      end
      HOLDOFF: begin
        if (any_flt)                    st_d    = ACTIVE;
        else if (timer_q == i_hold_cyc) st_d    = IDLE;
        else                            timer_d = timer_q + 1'b1;
      end
      LOCKOUT: begin
        if (i_clr && !any_flt) begin
          st_d    = IDLE;
          retry_d = '0;
        end
      end
      default: st_d = IDLE;
    endcase
    pwm_d  = pwm_for_state(st_d, kill);
    intb_d = ~((st_d != IDLE) | (|sticky_d));
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      flt_q    <= '0;
      sticky_q <= '0;
      st_q     <= IDLE;
      retry_q  <= '0;
      timer_q  <= '0;
      pwm_q    <= 1'b0;
      intb_q   <= 1'b1;
    end else begin
      flt_q    <= flt_d;
      sticky_q <= sticky_d;
      st_q     <= st_d;
      retry_q  <= retry_d;
      timer_q  <= timer_d;
      pwm_q    <= pwm_d;
      intb_q   <= intb_d;
    end
  end

  assign o_err_flt     = flt_q;
  assign o_err_sticky  = sticky_q;
  assign o_fault       = (st_q != IDLE);
  assign o_pwm_en_mask = pwm_q;
  assign o_intb_n      = intb_q;
  assign o_flt_st      = st_q;
  assign o_retry_cnt   = retry_q;

endmodule
